hazard_scoreboard: RTL and testbench
====================================

Name: hazard_scoreboard

Overview:
- Parametrised successor to the ID-stage stall logic.
- Replaces fixed load-use and branch comparisons with a per-register latency scoreboard. Supports configurable load latency, a single multi-cycle long-latency unit (div/mul), structural and WAW stalls, EX-stage flush, and a stall-cycle performance counter.
- Sits beside the ID stage and drives the IF/ID hold and ID/EX bubble.

Parameters:
- REG_AW, 5: register address width; 2**REG_AW registers, x0 never tracked.
- LAT_W, 3: scoreboard counter width; the all-ones code means LONG pending.
- ALU_LAT, 1: cycles until an ALU result is forwardable.
- LOAD_LAT, 2: cycles until load data is forwardable. Must be < 2**LAT_W-1.
- EX_SLACK, 1: maximum counter value at which an EX-use source may issue.
- BR_SLACK, 0: maximum counter value at which an ID-resolved branch source may proceed.
- PERF_W, 32: stall counter width.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- id_valid  in  1  valid instruction in ID
- id_rs1, id_rs2  in  REG_AW  source registers
- id_use_rs1, id_use_rs2  in  1  source actually read
- id_is_branch  in  1  branch resolved in ID
- id_reg_write  in  1  instruction writes rd
- id_rd  in  REG_AW  destination
- id_lat_class  in  2  0=ALU, 1=LOAD, 2=LONG, 3=reserved (treated as ALU)
- ex_flush  in  1  kill instruction in EX and the one in ID
- lu_done  in  1  long unit writeback this cycle
- lu_rd  in  REG_AW  long unit destination
- stall  out  1  hold IF/ID, bubble ID/EX
- stall_cause  out  2  0 none, 1 data/WAW, 2 branch, 3 structural
- sb_pending  out  2**REG_AW  bit r = counter[r] != 0
- stall_count  out  PERF_W  cycles with stall=1

Behaviour:
- Reset: all counters 0, long_busy 0, last-issue record cleared, stall_count 0.
- Scoreboard state:
  - One LAT_W counter per register. Value c means the result becomes forwardable in c cycles.
  - All-ones = LONG; it is cleared only by a matching lu_done or by a flush.
- Stall and stall_cause are combinational from registered state plus current ID inputs. Zero latency.
- Stall conditions (all require id_valid). Only used sources with nonzero address are checked:
  - Data: cnt[rs] > EX_SLACK. LONG always exceeds.
  - Branch: id_is_branch and cnt[rs] > BR_SLACK.
  - WAW: id_reg_write, id_rd != 0, and cnt[id_rd] == LONG. Reports cause 1.
  - Structural: id_lat_class == 2 and long_busy. Uses the registered value; no bypass from same-cycle lu_done.
  - Cause priority: 3 > 2 > 1.
- Issue: id_valid && !stall && !ex_flush.
  - On the issue edge, if id_reg_write && id_rd != 0, cnt[id_rd] <= ALU_LAT, LOAD_LAT or LONG per class. This overwrites any fixed-latency value.
  - A LONG issue sets long_busy.
  - Record last_rd, last_valid and last_long.
- Every edge: every counter not written and not LONG decrements, saturating at 0. Decrement is independent of stall.
- lu_done:
  - If cnt[lu_rd] == LONG, clear it to 0 and clear long_busy.
  - If cnt[lu_rd] is not LONG, ignore it, but still clear long_busy.
  - If issue targets the same rd in the same cycle, issue wins.
- ex_flush:
  - Suppresses issue this cycle.
  - If last_valid, clears cnt[last_rd]; if last_long, also clears long_busy. The long unit drops the killed op and never signals lu_done for it.
  - Then clears last_valid.
- stall_count increments on every cycle with stall=1 and wraps at 2**PERF_W.
- Mid-operation reset returns everything to reset values immediately.
- Worked timing with default parameters:
  - Load issued at t gives cnt=2 at t+1, so a dependent EX-use stalls 1 cycle and a dependent branch stalls 2.
  - ALU producer gives cnt=1, so an EX-use has no stall and a branch stalls 1.

Decomposition:
- Shared package holds:
  - lat-class codes (LC_ALU, LC_LOAD, LC_LONG)
  - stall-cause codes
  - LONG sentinel derived from LAT_W
- One sub-module, sb_entry: a single counter with load, decrement, LONG and clear controls, instantiated 2**REG_AW-1 times via generate.
- Stall evaluation and long_busy stay in the top.

Test Plan:
- LOAD x5 issues at t; at t+1 ADD reads x5 → stall=1, cause=1 at t+1; stall=0 at t+2; stall_count=1.
- ALU writes x6; at t+1 BEQ reads x6 → one stall cycle, cause=2. Repeat after LOAD x6 → two stall cycles.
- DIV x7 issued; second DIV → stall cause=3 until lu_done. ADD using x7 → cause=1 until the cycle after lu_done(x7); sb_pending[7]=0 afterwards.
- WAW: DIV x8 pending, ALU writing x8 in ID → stall cause=1; released the cycle after lu_done(x8).
- LOAD x9 issued, ex_flush next cycle → cnt[9]=0 and sb_pending[9]=0 next cycle; ID consumer of x9 not stalled; flushed DIV clears long_busy.
- Reads of x0 and use flags low → never stall. rst_n low mid-LONG → sb_pending=0, stall_count=0, stall=0.

Source files
------------

// File: rtl/hazard_scoreboard_pkg.sv
// Shared codes for the ID-stage hazard scoreboard: latency classes, stall causes
// and the LONG sentinel derived from the counter width.
package hazard_scoreboard_pkg;

    typedef enum logic [1:0] {
        LC_ALU  = 2'd0,
        LC_LOAD = 2'd1,
        LC_LONG = 2'd2,
        LC_RSVD = 2'd3
    } lat_class_e;

    typedef enum logic [1:0] {
        SC_NONE   = 2'd0,
        SC_DATA   = 2'd1,
        SC_BRANCH = 2'd2,
        SC_STRUCT = 2'd3
    } stall_cause_e;

    // All-ones counter code marks a result owned by the long-latency unit.
    function automatic int unsigned long_code(input int unsigned lat_w);
        return (32'd1 << lat_w) - 32'd1;
    endfunction

endpackage

// File: rtl/hazard_scoreboard_sb_entry.sv
// One scoreboard counter: load on issue, clear on long-unit writeback or flush,
// otherwise count down to zero; the LONG code holds until explicitly cleared.
module sb_entry
    import hazard_scoreboard_pkg::*;
#(
    parameter int LAT_W = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_i,
    input  logic [LAT_W-1:0] load_val_i,
    input  logic             clear_i,
    output logic [LAT_W-1:0] cnt_o
);

    localparam logic [LAT_W-1:0] LONG = LAT_W'(long_code(LAT_W));

    logic [LAT_W-1:0] cnt_q, cnt_d;

    // A same-cycle issue to this register takes precedence over any clear.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (clear_i) begin
            cnt_d = '0;
        end else if (cnt_q != LONG && cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/hazard_scoreboard.sv
// Per-register latency scoreboard beside ID: stall is combinational from registered
// state and current ID fields; issue, writeback and flush update state on the edge.
module hazard_scoreboard
    import hazard_scoreboard_pkg::*;
#(
    parameter int REG_AW   = 5,
    parameter int LAT_W    = 3,
    parameter int ALU_LAT  = 1,
    parameter int LOAD_LAT = 2,
    parameter int EX_SLACK = 1,
    parameter int BR_SLACK = 0,
    parameter int PERF_W   = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  id_valid,
    input  logic [REG_AW-1:0]     id_rs1,
    input  logic [REG_AW-1:0]     id_rs2,
    input  logic                  id_use_rs1,
    input  logic                  id_use_rs2,
    input  logic                  id_is_branch,
    input  logic                  id_reg_write,
    input  logic [REG_AW-1:0]     id_rd,
    input  logic [1:0]            id_lat_class,
    input  logic                  ex_flush,
    input  logic                  lu_done,
    input  logic [REG_AW-1:0]     lu_rd,
    output logic                  stall,
    output logic [1:0]            stall_cause,
    output logic [2**REG_AW-1:0]  sb_pending,
    output logic [PERF_W-1:0]     stall_count
);

    localparam int NREG = 2**REG_AW;
    localparam logic [LAT_W-1:0] LONG       = LAT_W'(long_code(LAT_W));
    localparam logic [LAT_W-1:0] EX_SLACK_C = LAT_W'(EX_SLACK);
    localparam logic [LAT_W-1:0] BR_SLACK_C = LAT_W'(BR_SLACK);

    logic [LAT_W-1:0]  cnt [NREG];
    lat_class_e        cls;
    stall_cause_e      cause;
    logic              data_hz, br_hz, struct_hz;
    logic              issue, wr_en;
    logic [LAT_W-1:0]  issue_lat;

    logic              long_busy_q, long_busy_d;
    logic              last_valid_q, last_valid_d;
    logic              last_long_q, last_long_d;
    logic [REG_AW-1:0] last_rd_q, last_rd_d;
    logic [PERF_W-1:0] stall_count_q, stall_count_d;

    assign cls = lat_class_e'(id_lat_class);

    always_comb begin
        data_hz   = 1'b0;
        br_hz     = 1'b0;
        struct_hz = 1'b0;
        if (id_valid) begin
            if (id_use_rs1 && id_rs1 != '0) begin
                if (cnt[id_rs1] > EX_SLACK_C) data_hz = 1'b1;
                if (id_is_branch && cnt[id_rs1] > BR_SLACK_C) br_hz = 1'b1;
            end
            if (id_use_rs2 && id_rs2 != '0) begin
                if (cnt[id_rs2] > EX_SLACK_C) data_hz = 1'b1;
                if (id_is_branch && cnt[id_rs2] > BR_SLACK_C) br_hz = 1'b1;
            end
            if (id_reg_write && id_rd != '0 && cnt[id_rd] == LONG) data_hz = 1'b1;
            // Registered busy only: a same-cycle lu_done does not release the unit.
            if (cls == LC_LONG && long_busy_q) struct_hz = 1'b1;
        end
        if (struct_hz)    cause = SC_STRUCT;
        else if (br_hz)   cause = SC_BRANCH;
        else if (data_hz) cause = SC_DATA;
        else              cause = SC_NONE;
    end

    assign stall       = data_hz | br_hz | struct_hz;
    assign stall_cause = cause;
    assign issue       = id_valid && !stall && !ex_flush;
    assign wr_en       = issue && id_reg_write && id_rd != '0;

    always_comb begin
        case (cls)
            LC_LOAD: issue_lat = LAT_W'(LOAD_LAT);
            LC_LONG: issue_lat = LONG;
            default: issue_lat = LAT_W'(ALU_LAT);
        endcase
    end

    assign cnt[0] = '0;

    for (genvar r = 1; r < NREG; r++) begin : g_entry
        logic load, clear;
        assign load  = wr_en && id_rd == REG_AW'(r);
        assign clear = (lu_done && lu_rd == REG_AW'(r) && cnt[r] == LONG) ||
                       (ex_flush && last_valid_q && last_rd_q == REG_AW'(r));
        sb_entry #(.LAT_W(LAT_W)) u_entry (
            .clk        (clk),
            .rst_n      (rst_n),
            .load_i     (load),
            .load_val_i (issue_lat),
            .clear_i    (clear),
            .cnt_o      (cnt[r])
        );
    end

    always_comb begin
        for (int i = 0; i < NREG; i++) begin
            sb_pending[i] = (cnt[i] != '0);
        end
    end

    // Flush kills the op recorded at the last issue; a killed long op never writes back.
    always_comb begin
        long_busy_d   = long_busy_q;
        last_valid_d  = last_valid_q;
        last_long_d   = last_long_q;
        last_rd_d     = last_rd_q;
        stall_count_d = stall_count_q;
        if (ex_flush && last_valid_q) begin
            if (last_long_q) long_busy_d = 1'b0;
            last_valid_d = 1'b0;
        end
        if (lu_done) long_busy_d = 1'b0;
        if (issue) begin
            if (cls == LC_LONG) long_busy_d = 1'b1;
            last_valid_d = 1'b1;
            last_long_d  = (cls == LC_LONG);
            last_rd_d    = id_reg_write ? id_rd : '0;
        end
        if (stall) stall_count_d = stall_count_q + PERF_W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            long_busy_q   <= 1'b0;
            last_valid_q  <= 1'b0;
            last_long_q   <= 1'b0;
            last_rd_q     <= '0;
            stall_count_q <= '0;
        end else begin
            long_busy_q   <= long_busy_d;
            last_valid_q  <= last_valid_d;
            last_long_q   <= last_long_d;
            last_rd_q     <= last_rd_d;
            stall_count_q <= stall_count_d;
        end
    end

    assign stall_count = stall_count_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed hazard scenarios plus random traffic, checked each cycle against a
// ready-time model of the register file and long unit.
module tb_hazard_scoreboard;

    localparam int NREG     = 32;
    localparam int LONGV    = 7;
    localparam int ALU_LAT  = 1;
    localparam int LOAD_LAT = 2;
    localparam int EX_SLACK = 1;
    localparam int BR_SLACK = 0;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        id_valid = 1'b0;
    logic [4:0]  id_rs1 = '0, id_rs2 = '0, id_rd = '0, lu_rd = '0;
    logic        id_use_rs1 = 1'b0, id_use_rs2 = 1'b0, id_is_branch = 1'b0;
    logic        id_reg_write = 1'b0, ex_flush = 1'b0, lu_done = 1'b0;
    logic [1:0]  id_lat_class = '0;
    logic        stall;
    logic [1:0]  stall_cause;
    logic [31:0] sb_pending, stall_count;

    hazard_scoreboard #(
        .REG_AW(5), .LAT_W(3), .ALU_LAT(ALU_LAT), .LOAD_LAT(LOAD_LAT),
        .EX_SLACK(EX_SLACK), .BR_SLACK(BR_SLACK), .PERF_W(32)
    ) dut (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_is_branch(id_is_branch),
        .id_reg_write(id_reg_write), .id_rd(id_rd), .id_lat_class(id_lat_class),
        .ex_flush(ex_flush), .lu_done(lu_done), .lu_rd(lu_rd), .stall(stall),
        .stall_cause(stall_cause), .sb_pending(sb_pending), .stall_count(stall_count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Model: absolute cycle at which each result is ready, plus a long-pending flag.
    int          m_ready [NREG];
    bit          m_long [NREG];
    bit          m_busy, m_lv, m_ll;
    int          m_lrd, m_now, lu_tgt;
    logic [31:0] m_cnt;

    task automatic model_reset();
        for (int r = 0; r < NREG; r++) begin
            m_ready[r] = 0;
            m_long[r]  = 0;
        end
        m_busy = 0; m_lv = 0; m_ll = 0; m_lrd = 0; m_cnt = 0; lu_tgt = 0;
    endtask

    function automatic int rem(input int r);
        if (r == 0) return 0;
        if (m_long[r]) return LONGV;
        return (m_ready[r] > m_now) ? m_ready[r] - m_now : 0;
    endfunction

    task automatic model_eval(output bit st, output logic [1:0] cause);
        bit d = 0, b = 0, s = 0;
        int srcs [2];
        bit uses [2];
        srcs[0] = int'(id_rs1); srcs[1] = int'(id_rs2);
        uses[0] = id_use_rs1;   uses[1] = id_use_rs2;
        if (id_valid) begin
            for (int k = 0; k < 2; k++) begin
                if (uses[k] && srcs[k] != 0) begin
                    if (rem(srcs[k]) > EX_SLACK) d = 1;
                    if (id_is_branch && rem(srcs[k]) > BR_SLACK) b = 1;
                end
            end
            if (id_reg_write && id_rd != 0 && m_long[id_rd]) d = 1;
            if (id_lat_class == 2 && m_busy) s = 1;
        end
        cause = s ? 2'd3 : b ? 2'd2 : d ? 2'd1 : 2'd0;
        st = s | b | d;
    endtask

    task automatic model_edge(input bit s);
        bit iss = id_valid && !s && !ex_flush;
        int rd = int'(id_rd);
        if (ex_flush && m_lv) begin
            m_long[m_lrd] = 0;
            m_ready[m_lrd] = 0;
            if (m_ll) m_busy = 0;
            m_lv = 0;
        end
        if (lu_done) begin
            if (m_long[lu_rd]) begin
                m_long[lu_rd] = 0;
                m_ready[lu_rd] = 0;
            end
            m_busy = 0;
        end
        if (iss) begin
            if (id_reg_write && rd != 0) begin
                if (id_lat_class == 2) m_long[rd] = 1;
                else begin
                    m_long[rd] = 0;
                    m_ready[rd] = m_now + 1 + ((id_lat_class == 1) ? LOAD_LAT : ALU_LAT);
                end
            end
            if (id_lat_class == 2) begin
                m_busy = 1;
                lu_tgt = id_reg_write ? rd : 0;
            end
            m_lv = 1; m_ll = (id_lat_class == 2); m_lrd = id_reg_write ? rd : 0;
        end
        if (s) m_cnt++;
        m_now++;
    endtask

    task automatic cycle(output bit st);
        bit s;
        logic [1:0] c;
        logic [31:0] pend;
        @(negedge clk);
        model_eval(s, c);
        pend = '0;
        for (int r = 0; r < NREG; r++) if (rem(r) != 0) pend[r] = 1'b1;
        chk("stall", {31'd0, stall}, {31'd0, s});
        chk("cause", {30'd0, stall_cause}, {30'd0, c});
        chk("pending", sb_pending, pend);
        chk("count", stall_count, m_cnt);
        model_edge(s);
        st = s;
        @(posedge clk);
        #1;
    endtask

    task automatic drv(input bit v, input int rs1, input bit u1, input int rs2, input bit u2,
                       input bit br, input bit wr, input int rd, input int cls);
        id_valid = v; id_rs1 = rs1[4:0]; id_use_rs1 = u1; id_rs2 = rs2[4:0]; id_use_rs2 = u2;
        id_is_branch = br; id_reg_write = wr; id_rd = rd[4:0]; id_lat_class = cls[1:0];
        ex_flush = 1'b0; lu_done = 1'b0; lu_rd = '0;
    endtask

    task automatic run_until_issue(input string tag, input int exp_stalls);
        int n = 0;
        bit s = 1;
        for (int k = 0; k < exp_stalls + 4 && s; k++) begin
            cycle(s);
            if (s) n++;
        end
        chk(tag, n, exp_stalls);
        drv(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic hold(input int n);
        bit s;
        for (int k = 0; k < n; k++) cycle(s);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        model_reset();
        @(negedge clk);
        chk("rst_stall", {31'd0, stall}, 32'd0);
        chk("rst_pending", sb_pending, 32'd0);
        chk("rst_count", stall_count, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        bit s;
        m_now = 0;
        model_reset();
        @(posedge clk);
        #1;
        do_reset();

        // Load-use: one stall for an EX consumer.
        drv(1, 0, 0, 0, 0, 0, 1, 5, 1);  run_until_issue("ld5_issue", 0);
        drv(1, 5, 1, 0, 0, 0, 1, 10, 0); run_until_issue("ld_use", 1);
        chk("ld_use_count", stall_count, 32'd1);
        hold(3);

        // Branch after ALU (one stall) and after load (two stalls).
        drv(1, 0, 0, 0, 0, 0, 1, 6, 0);  run_until_issue("alu6_issue", 0);
        drv(1, 6, 1, 0, 1, 1, 0, 0, 0);  run_until_issue("alu_br", 1);
        drv(1, 0, 0, 0, 0, 0, 1, 6, 1);  run_until_issue("ld6_issue", 0);
        drv(1, 6, 1, 0, 0, 1, 0, 0, 0);  run_until_issue("ld_br", 2);
        hold(3);

        // Long unit: data stall on x7, structural stall on a second DIV.
        drv(1, 0, 0, 0, 0, 0, 1, 7, 2);  run_until_issue("div7_issue", 0);
        drv(1, 7, 1, 0, 0, 0, 1, 10, 0); hold(3);
        chk("div_use_cause", {30'd0, stall_cause}, 32'd1);
        drv(1, 0, 0, 0, 0, 0, 1, 11, 2); hold(2);
        chk("struct_cause", {30'd0, stall_cause}, 32'd3);
        lu_done = 1'b1; lu_rd = 5'd7; cycle(s);
        chk("struct_at_done", {31'd0, s}, 32'd1);
        lu_done = 1'b0;
        run_until_issue("div11_after_done", 0);
        chk("x7_released", {31'd0, sb_pending[7]}, 32'd0);
        drv(1, 11, 1, 0, 0, 0, 1, 10, 0); hold(2);
        lu_done = 1'b1; lu_rd = 5'd11; cycle(s);
        lu_done = 1'b0;
        run_until_issue("use11_after_done", 0);

        // WAW against a pending long result.
        drv(1, 0, 0, 0, 0, 0, 1, 8, 2);  run_until_issue("div8_issue", 0);
        drv(1, 0, 0, 0, 0, 0, 1, 8, 0);  hold(2);
        chk("waw_cause", {30'd0, stall_cause}, 32'd1);
        lu_done = 1'b1; lu_rd = 5'd8; cycle(s);
        lu_done = 1'b0;
        run_until_issue("waw_release", 0);

        // Flush of a load and of a long op.
        drv(1, 0, 0, 0, 0, 0, 1, 9, 1);  run_until_issue("ld9_issue", 0);
        drv(1, 9, 1, 0, 0, 0, 1, 10, 0); ex_flush = 1'b1; cycle(s);
        chk("flush_x9_pending", {31'd0, sb_pending[9]}, 32'd0);
        ex_flush = 1'b0;
        run_until_issue("flush_consumer", 0);
        drv(1, 0, 0, 0, 0, 0, 1, 12, 2); run_until_issue("div12_issue", 0);
        drv(1, 0, 0, 0, 0, 0, 1, 13, 2); ex_flush = 1'b1; cycle(s);
        ex_flush = 1'b0;
        run_until_issue("div_after_flush", 0);
        drv(0, 0, 0, 0, 0, 0, 0, 0, 0); lu_done = 1'b1; lu_rd = 5'd13; cycle(s);

        // x0 sources and unused sources never stall.
        drv(1, 0, 0, 0, 0, 0, 1, 14, 2); run_until_issue("div14_issue", 0);
        drv(1, 0, 1, 0, 1, 1, 1, 0, 0);  run_until_issue("x0_src", 0);
        drv(1, 14, 0, 14, 0, 1, 1, 15, 0); run_until_issue("unused_src", 0);

        // Reset while a long op is pending and a dependent sits in ID.
        drv(1, 14, 1, 0, 0, 1, 0, 0, 0);
        do_reset();
        hold(2);

        // Random traffic over a small register window to provoke hazards.
        for (int t = 0; t < 1500; t++) begin
            drv($urandom_range(0, 9) < 8, $urandom_range(0, 7), $urandom_range(0, 1),
                $urandom_range(0, 7), $urandom_range(0, 1), $urandom_range(0, 3) == 0,
                $urandom_range(0, 1), $urandom_range(0, 7), $urandom_range(0, 3));
            ex_flush = ($urandom_range(0, 11) == 0);
            if (m_busy && $urandom_range(0, 4) == 0) begin
                lu_done = 1'b1;
                lu_rd = lu_tgt[4:0];
            end else if ($urandom_range(0, 39) == 0) begin
                lu_done = 1'b1;
                lu_rd = 5'($urandom_range(0, 7));
            end
            cycle(s);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
